// File: rtl/image_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : image_ram_arbiter
// Description : Single-port image RAM arbiter, VGA fixed priority with a
//               CPU anti-starvation slot and a 2-stage read-return pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module image_ram_arbiter #(
  parameter int AW           = 8,
  parameter int DW           = 24,
  parameter int STARVE_LIMIT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  input  logic          vga_req,
  input  logic [AW-1:0] vga_addr,
  output logic          vga_gnt,
  output logic          vga_valid,
  output logic [DW-1:0] vga_data,
  output logic          vga_stall,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_we,
  input  logic [DW-1:0] ram_dout
);

  localparam int            CW          = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] C_LIMIT     = CW'(STARVE_LIMIT);
  localparam bit            C_FORCE_EN  = (STARVE_LIMIT != 0);

  logic [CW-1:0] starve_cnt_q, starve_cnt_d;
  logic          s1_v_q, s1_v_d;
  logic          s1_cpu_q, s1_cpu_d;
  logic          s1_we_q, s1_we_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic          vga_valid_q, vga_valid_d;
  logic [DW-1:0] vga_data_q, vga_data_d;
  logic          vga_stall_q, vga_stall_d;
  logic          w_force;
  logic          w_cpu_gnt;
  logic          w_vga_gnt;

  always_comb begin
    w_force   = C_FORCE_EN && cpu_req && (starve_cnt_q >= C_LIMIT);
    w_vga_gnt = vga_req && !w_force;
    w_cpu_gnt = cpu_req && !w_vga_gnt;

    // A forced grant also lands here, so VGA wins again on the next cycle.
    starve_cnt_d = starve_cnt_q;
    if (w_cpu_gnt || !cpu_req) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q < C_LIMIT) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end

    s1_v_d   = w_cpu_gnt || w_vga_gnt;
    s1_cpu_d = w_cpu_gnt;
    s1_we_d  = w_cpu_gnt && cpu_we;

    // Stage 2: ram_dout now holds the data for the access registered in stage 1.
    cpu_ack_d   = s1_v_q && s1_cpu_q;
    vga_valid_d = s1_v_q && !s1_cpu_q;
    cpu_rdata_d = (cpu_ack_d && !s1_we_q) ? ram_dout : cpu_rdata_q;
    vga_data_d  = vga_valid_d ? ram_dout : vga_data_q;
    vga_stall_d = vga_req && w_force;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt_q <= '0;
      s1_v_q       <= 1'b0;
      s1_cpu_q     <= 1'b0;
      s1_we_q      <= 1'b0;
      cpu_ack_q    <= 1'b0;
      cpu_rdata_q  <= '0;
      vga_valid_q  <= 1'b0;
      vga_data_q   <= '0;
      vga_stall_q  <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      s1_v_q       <= s1_v_d;
      s1_cpu_q     <= s1_cpu_d;
      s1_we_q      <= s1_we_d;
      cpu_ack_q    <= cpu_ack_d;
      cpu_rdata_q  <= cpu_rdata_d;
      vga_valid_q  <= vga_valid_d;
      vga_data_q   <= vga_data_d;
      vga_stall_q  <= vga_stall_d;
    end
  end

  assign cpu_gnt   = w_cpu_gnt;
  assign vga_gnt   = w_vga_gnt;
  assign ram_addr  = w_cpu_gnt ? cpu_addr : vga_addr;
  assign ram_din   = cpu_wdata;
  assign ram_we    = w_cpu_gnt && cpu_we;
  assign cpu_ack   = cpu_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign vga_valid = vga_valid_q;
  assign vga_data  = vga_data_q;
  assign vga_stall = vga_stall_q;

endmodule
`default_nettype wire

// File: tb/tb_image_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_image_ram_arbiter
// Description : Directed self-checking bench for image_ram_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_image_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  int          errors = 0;
  int          checks = 0;

  // Instance A: default starvation limit
  logic        cpu_req, cpu_we, vga_req;
  logic [7:0]  cpu_addr, vga_addr;
  logic [23:0] cpu_wdata;
  logic        cpu_gnt, cpu_ack, vga_gnt, vga_valid, vga_stall, ram_we;
  logic [23:0] cpu_rdata, vga_data, ram_din;
  logic [7:0]  ram_addr;
  logic [23:0] ram_dout;
  logic [23:0] mem_a [256];

  // Instance B: starvation forcing disabled
  logic        b_cpu_req, b_vga_req;
  logic [7:0]  b_vga_addr;
  logic        b_cpu_gnt, b_cpu_ack, b_vga_gnt, b_vga_valid, b_vga_stall, b_ram_we;
  logic [23:0] b_cpu_rdata, b_vga_data, b_ram_din;
  logic [7:0]  b_ram_addr;
  logic [23:0] b_ram_dout;
  logic [23:0] mem_b [256];

  always #5 clk = ~clk;

  image_ram_arbiter #(.AW(8), .DW(24), .STARVE_LIMIT(15)) u_dut_a (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt),
    .vga_valid(vga_valid), .vga_data(vga_data), .vga_stall(vga_stall),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
  );

  image_ram_arbiter #(.AW(8), .DW(24), .STARVE_LIMIT(0)) u_dut_b (
    .clk(clk), .reset(reset),
    .cpu_req(b_cpu_req), .cpu_we(1'b0), .cpu_addr(8'h55), .cpu_wdata(24'h0),
    .cpu_gnt(b_cpu_gnt), .cpu_ack(b_cpu_ack), .cpu_rdata(b_cpu_rdata),
    .vga_req(b_vga_req), .vga_addr(b_vga_addr), .vga_gnt(b_vga_gnt),
    .vga_valid(b_vga_valid), .vga_data(b_vga_data), .vga_stall(b_vga_stall),
    .ram_addr(b_ram_addr), .ram_din(b_ram_din), .ram_we(b_ram_we), .ram_dout(b_ram_dout)
  );

  // Synchronous single-port RAM models, read data one cycle after address.
  always @(posedge clk) begin
    if (ram_we) mem_a[ram_addr] <= ram_din;
    ram_dout <= mem_a[ram_addr];
  end

  always @(posedge clk) begin
    if (b_ram_we) mem_b[b_ram_addr] <= b_ram_din;
    b_ram_dout <= mem_b[b_ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0]  a;
    logic [23:0] e;
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 24'(i);
      mem_b[i] = 24'(i);
    end
    reset = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 24'h0;
    vga_req = 1'b1; vga_addr = 8'h20;
    b_cpu_req = 1'b0; b_vga_req = 1'b0; b_vga_addr = 8'h00;

    // 1: reset held with both requests active
    step(); step(); step();
    @(negedge clk);
    check("rst_cpu_ack",   32'(cpu_ack),   32'd0);
    check("rst_vga_valid", 32'(vga_valid), 32'd0);
    check("rst_vga_stall", 32'(vga_stall), 32'd0);
    check("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    check("rst_vga_data",  32'(vga_data),  32'd0);
    step();
    reset = 1'b0;
    @(negedge clk);
    check("rel_vga_gnt", 32'(vga_gnt), 32'd1);
    check("rel_cpu_gnt", 32'(cpu_gnt), 32'd0);
    step();
    cpu_req = 1'b0; vga_req = 1'b0;
    step(); step();
    @(negedge clk);
    check("idle_ram_we",   32'(ram_we),   32'd0);
    check("idle_ram_addr", 32'(ram_addr), 32'h20);
    step();

    // 2: write 0x10 then read it back the next cycle
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h10; cpu_wdata = 24'hA1B2C3;
    @(negedge clk);
    check("wr_cpu_gnt",  32'(cpu_gnt),  32'd1);
    check("wr_ram_we",   32'(ram_we),   32'd1);
    check("wr_ram_addr", 32'(ram_addr), 32'h10);
    check("wr_ram_din",  32'(ram_din),  32'hA1B2C3);
    step();
    cpu_we = 1'b0;
    @(negedge clk);
    check("rd_cpu_gnt", 32'(cpu_gnt), 32'd1);
    check("rd_ram_we",  32'(ram_we),  32'd0);
    check("rd_ack_n1",  32'(cpu_ack), 32'd0);
    step();
    cpu_req = 1'b0;
    @(negedge clk);
    check("wr_ack",        32'(cpu_ack),   32'd1);
    check("wr_rdata_hold", 32'(cpu_rdata), 32'd0);
    step();
    @(negedge clk);
    check("rd_ack",   32'(cpu_ack),   32'd1);
    check("rd_rdata", 32'(cpu_rdata), 32'hA1B2C3);
    step();
    @(negedge clk);
    check("ack_drop", 32'(cpu_ack), 32'd0);
    step();

    // 3: starvation slot with both requesters active
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h30;
    vga_req = 1'b1; vga_addr = 8'h20;
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      if (i < 15) begin
        check("stv_vga_gnt", 32'(vga_gnt), 32'd1);
        check("stv_cpu_gnt", 32'(cpu_gnt), 32'd0);
      end
      if (i == 14) check("stv_no_stall", 32'(vga_stall), 32'd0);
      if (i == 15) begin
        check("stv_force_cpu", 32'(cpu_gnt),  32'd1);
        check("stv_force_vga", 32'(vga_gnt),  32'd0);
        check("stv_force_adr", 32'(ram_addr), 32'h30);
      end
      if (i == 16) begin
        check("stv_stall",      32'(vga_stall), 32'd1);
        check("stv_vga_resume", 32'(vga_gnt),   32'd1);
        check("stv_valid16",    32'(vga_valid), 32'd1);
        check("stv_vdata16",    32'(vga_data),  32'h20);
      end
      if (i == 17) begin
        check("stv_stall_clr", 32'(vga_stall), 32'd0);
        check("stv_cpu_ack",   32'(cpu_ack),   32'd1);
        check("stv_cpu_rdata", 32'(cpu_rdata), 32'h30);
        check("stv_vgap",      32'(vga_valid), 32'd0);
      end
      step();
      if (i == 15) cpu_req = 1'b0;
    end

    // 5: VGA streams the whole address space with wrap
    for (int i = 0; i < 260; i++) begin
      vga_addr = 8'(i);
      @(negedge clk);
      check("str_vga_gnt",  32'(vga_gnt),  32'd1);
      check("str_ram_addr", 32'(ram_addr), 32'(i & 255));
      if (i >= 2) begin
        a = 8'(i - 2);
        e = (a == 8'h10) ? 24'hA1B2C3 : 24'(a);
        check("str_vga_valid", 32'(vga_valid), 32'd1);
        check("str_vga_data",  32'(vga_data),  32'(e));
      end
      step();
    end
    vga_req = 1'b0;

    // 4: forcing disabled, CPU never wins against continuous VGA
    for (int i = 0; i < 100; i++) begin
      b_cpu_req = 1'b1; b_vga_req = 1'b1; b_vga_addr = 8'(i);
      @(negedge clk);
      check("nf_cpu_gnt", 32'(b_cpu_gnt), 32'd0);
      if (i >= 2) begin
        check("nf_vga_valid", 32'(b_vga_valid), 32'd1);
        check("nf_vga_data",  32'(b_vga_data),  32'(i - 2));
      end
      step();
    end
    b_cpu_req = 1'b0; b_vga_req = 1'b0;
    step(); step(); step();

    // 6: reset one cycle after a CPU read grant
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h20;
    @(negedge clk);
    check("mr_cpu_gnt", 32'(cpu_gnt), 32'd1);
    step();
    cpu_req = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("mr_ack_n1", 32'(cpu_ack), 32'd0);
    step();
    reset = 1'b0;
    @(negedge clk);
    check("mr_ack_n2",   32'(cpu_ack),   32'd0);
    check("mr_rdata_rst", 32'(cpu_rdata), 32'd0);
    step();
    @(negedge clk);
    check("mr_ack_n3", 32'(cpu_ack), 32'd0);
    step();
    cpu_req = 1'b1; cpu_addr = 8'h40;
    @(negedge clk);
    check("pr_cpu_gnt", 32'(cpu_gnt), 32'd1);
    step();
    cpu_req = 1'b0;
    @(negedge clk);
    check("pr_ack_n1", 32'(cpu_ack), 32'd0);
    step();
    @(negedge clk);
    check("pr_ack",   32'(cpu_ack),   32'd1);
    check("pr_rdata", 32'(cpu_rdata), 32'h40);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
